// File: rtl/sevenseg_scan_driver_if.sv
// Bundle of the data/control inputs and display outputs of the 7-segment scan driver.
// The driver sits on the slave modport; whatever feeds it (datapath or bench) uses master.
interface sevenseg_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value, load, digit_en, blank,
    input  seg, an, frame_done
  );

  modport slave (
    input  value, load, digit_en, blank,
    output seg, an, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed hex 7-segment driver: double-buffered value, per-slot dead time, frame pulse.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module sevenseg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  sevenseg_scan_driver_if.slave bus
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ValW-1:0]       pending_q, pending_d;
  logic [ValW-1:0]       shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic       tick, last_digit, frame_wrap;
  logic       in_dead_time, suppressed, dark;
  logic [3:0] nibble;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h1:    s = 7'h4F;
      4'h2:    s = 7'h12;
      4'h3:    s = 7'h06;
      4'h4:    s = 7'h4C;
      4'h5:    s = 7'h24;
      4'h6:    s = 7'h20;
      4'h7:    s = 7'h0F;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h0C;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h60;
      4'hC:    s = 7'h31;
      4'hD:    s = 7'h42;
      4'hE:    s = 7'h30;
      4'hF:    s = 7'h38;
      default: s = 7'h01;
    endcase
    return s;
  endfunction

  assign tick       = (cnt_q == CntW'(REFRESH_DIV - 1));
  assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign frame_wrap = tick & last_digit;

  // Scan position and buffering
  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CntW'(1);
    idx_d        = idx_q;
    if (tick) idx_d = last_digit ? '0 : idx_q + IdxW'(1);
    pending_d    = bus.load ? bus.value : pending_q;
    // Shadow only moves on the frame boundary; a coincident load bypasses pending.
    shadow_d     = frame_wrap ? (bus.load ? bus.value : pending_q) : shadow_q;
    frame_done_d = frame_wrap;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_supp;
  logic                  zero_run;

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_supp  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (shadow_q[4*i +: 4] == 4'h0);
      lz_supp[i] = (i != 0) && zero_run;
    end
  end

  assign suppressed = lz_supp[idx_q];
`else
  assign suppressed = 1'b0;
`endif

  assign in_dead_time = (32'(cnt_q) < BLANK_CYCLES);
  assign nibble       = shadow_q[4*idx_q +: 4];

  always_comb begin
    dark  = bus.blank | ~bus.digit_en[idx_q] | in_dead_time | suppressed;
    an_d  = dark ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d = dark ? 7'h7F : decode(nibble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      shadow_q     <= '0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
